pattern_gen: RTL and testbench
==============================

// Module: pattern_gen
// PURPOSE
//  Parametrised serial pattern generator for the glitch path; successor to the 8-bit pattern block.
//  Latches a WIDTH-bit pattern on a start pulse and shifts it out serially on out.
//  Bit period is programmable; pattern repeats pattern_cnt+1 times; bit order is selectable.
//  Provides rdy/done handshake and mid-run abort. Sits between the command decoder and the glitch output driver.
// PARAMETERS
//  WIDTH     8  pattern length in bits (>=2)
//  CNT_W     8  width of pattern_cnt (repeat count)
//  DIV_W     8  width of bit_div (clock cycles per bit minus 1)
//  IDLE_LVL  0  level driven on out while not shifting
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst_n        in   1      asynchronous active-low reset
//  en           in   1      start pulse; accepted only when rdy=1
//  abort        in   1      terminate current run
//  pattern      in   WIDTH  pattern to emit
//  pattern_cnt  in   CNT_W  extra repetitions (0 = emit once)
//  bit_div      in   DIV_W  each bit is held bit_div+1 cycles
//  lsb_first    in   1      1: bit0 first; 0: bit WIDTH-1 first
//  out          out  1      serial pattern output (registered)
//  rdy          out  1      1 = IDLE, able to accept en
//  done         out  1      one-cycle pulse on normal completion
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, out=IDLE_LVL, rdy=1, done=0, all counters 0.
//  - States: IDLE, SHIFT. IDLE->SHIFT on en&rdy&!abort; SHIFT->IDLE on last cycle of last bit of last repeat, or on abort.
//  - Start: en sampled at edge k in IDLE -> pattern, pattern_cnt, bit_div, lsb_first latched;
//    from edge k: out=first bit, rdy=0. Input changes after k are ignored until next start.
//  - Each bit held exactly bit_div+1 cycles (bit_div=0 -> one bit per clock); no gaps between bits or repeats.
//  - After WIDTH bits: if rep<pattern_cnt, reload from latched pattern, rep++, continue seamlessly.
//  - Run length: WIDTH*(bit_div+1)*(pattern_cnt+1) cycles; at edge k+run: state=IDLE, out=IDLE_LVL, rdy=1, done=1 for that cycle only.
//  - en in the done cycle is accepted (back-to-back runs, one IDLE_LVL cycle between them).
//  - en while SHIFT (rdy=0) is ignored; no queuing.
//  - abort in SHIFT: next edge -> IDLE, out=IDLE_LVL, rdy=1, done stays 0.
//  - abort and en in the same IDLE cycle: abort wins, no start.
//  - pattern_cnt max (all ones) repeats 2^CNT_W times; counters never wrap mid-run.
//  - rst_n asserted mid-run: immediate return to reset values, no done.
//  - out, rdy, done are registered outputs; no combinational path from inputs to outputs.
// TESTING
//  1. Reset: rst_n=0 -> out=0, rdy=1, done=0; release, no activity while en=0.
//  2. pattern=8'h55, cnt=0, div=0, msb-first, en pulse -> out 0,1,0,1,0,1,0,1 over 8 cycles; rdy=0 for 8 cycles; done 1 cycle.
//  3. pattern=8'hAA, cnt=2, div=0, lsb_first=1 -> 0,1,0,1,... for 24 cycles, no gaps; single done.
//  4. pattern=8'hF0, div=3 -> each bit held 4 cycles, 32 busy cycles; en pulses mid-run ignored.
//  5. Back-to-back: en in done cycle with 8'hAA -> second run starts next edge; pattern changed mid-run has no effect.
//  6. abort at cycle 3 of 8'h55 run -> out=IDLE_LVL, rdy=1 next edge, no done; rst_n pulse mid-run -> reset values immediately.

Source files
------------

// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - serial pattern generator: latches a WIDTH-bit pattern on start and shifts it out,
// with programmable bit period, repeat count, bit order and mid-run abort.
module pattern_gen #(
  parameter int   WIDTH    = 8,
  parameter int   CNT_W    = 8,
  parameter int   DIV_W    = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] pattern_cnt,
  input  logic [DIV_W-1:0] bit_div,
  input  logic             lsb_first,
  output logic             out,
  output logic             rdy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               lsb_q, lsb_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic               out_q, out_d;
  logic               done_q, done_d;

  // Position i in emission order, mapped to the physical pattern bit.
  function automatic logic pick(input logic [WIDTH-1:0] p, input logic [IDX_W-1:0] i,
                                input logic lsb);
    logic [IDX_W-1:0] k;
    k = lsb ? i : (LAST_IDX - i);
    return p[k];
  endfunction

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    lsb_d   = lsb_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    rep_d   = rep_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = IDLE_LVL;
        if (en && !abort) begin
          state_d = SHIFT;
          pat_d   = pattern;
          cnt_d   = pattern_cnt;
          div_d   = bit_div;
          lsb_d   = lsb_first;
          idx_d   = '0;
          dcnt_d  = '0;
          rep_d   = '0;
          out_d   = pick(pattern, '0, lsb_first);
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          out_d   = IDLE_LVL;
        end else if (dcnt_q != div_q) begin
          dcnt_d = dcnt_q + 1'b1;
        end else begin
          dcnt_d = '0;
          if (idx_q == LAST_IDX) begin
            // rep_q stops at cnt_q, so an all-ones count never wraps.
            if (rep_q == cnt_q) begin
              state_d = IDLE;
              out_d   = IDLE_LVL;
              done_d  = 1'b1;
            end else begin
              rep_d = rep_q + 1'b1;
              idx_d = '0;
              out_d = pick(pat_q, '0, lsb_q);
            end
          end else begin
            idx_d = idx_q + 1'b1;
            out_d = pick(pat_q, idx_q + 1'b1, lsb_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      lsb_q   <= 1'b0;
      idx_q   <= '0;
      dcnt_q  <= '0;
      rep_q   <= '0;
      out_q   <= IDLE_LVL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      lsb_q   <= lsb_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign rdy  = (state_q == IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// tb/tb_pattern_gen.sv - scoreboard bench for pattern_gen with hand-written emission sequences.
module tb_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       abort;
  logic [7:0] pattern;
  logic [7:0] pattern_cnt;
  logic [7:0] bit_div;
  logic       lsb_first;
  logic       out;
  logic       rdy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int   cyc;
    logic o;
    logic r;
    logic d;
  } exp_t;
  exp_t sb[$];

  pattern_gen #(.WIDTH(8), .CNT_W(8), .DIV_W(8), .IDLE_LVL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort), .pattern(pattern),
    .pattern_cnt(pattern_cnt), .bit_div(bit_div), .lsb_first(lsb_first),
    .out(out), .rdy(rdy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      if (sb[0].cyc < cyc) begin
        chk("sb_stale", sb[0].cyc, cyc);
      end else begin
        chk("out", int'(out), int'(sb[0].o));
        chk("rdy", int'(rdy), int'(sb[0].r));
        chk("done", int'(done), int'(sb[0].d));
      end
      void'(sb.pop_front());
    end
  end

  // Expectation for the state right after the next rising edge.
  task automatic tick(input logic eo, input logic er, input logic ed);
    exp_t e;
    e.cyc = cyc + 1;
    e.o = eo;
    e.r = er;
    e.d = ed;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // seq: emitted bit sequence, seq[7] first. noise perturbs en and all inputs mid-run.
  task automatic run(input logic [7:0] pat, input int cnt, input int div, input logic lsb,
                     input logic [7:0] seq, input bit noise, input int abort_at, input int rst_at);
    int len;
    int idx;
    len = 8 * (div + 1) * (cnt + 1);
    for (int j = 0; j < len; j++) begin
      if (j == 0) begin
        en          = 1'b1;
        pattern     = pat;
        pattern_cnt = 8'(cnt);
        bit_div     = 8'(div);
        lsb_first   = lsb;
      end else begin
        en = noise && (j % 3 == 1);
        if (noise) begin
          pattern     = ~pat;
          pattern_cnt = 8'(cnt + 3);
          bit_div     = 8'(div ^ 1);
          lsb_first   = ~lsb;
        end
      end
      if (j == abort_at) begin
        en    = 1'b0;
        abort = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        abort = 1'b0;
        return;
      end
      if (j == rst_at) begin
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_rdy", int'(rdy), 1);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      idx = (j / (div + 1)) % 8;
      tick(seq[7-idx], 1'b0, 1'b0);
    end
    en = 1'b0;
    tick(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    abort = 1'b0;
    pattern = 8'h00;
    pattern_cnt = 8'h00;
    bit_div = 8'h00;
    lsb_first = 1'b0;
    #1;
    chk("reset_out", int'(out), 0);
    chk("reset_rdy", int'(rdy), 1);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(1'b0, 1'b1, 1'b0);

    run(8'h55, 0, 0, 1'b0, 8'b01010101, 1'b0, -1, -1);
    tick(1'b0, 1'b1, 1'b0);
    run(8'hAA, 2, 0, 1'b1, 8'b01010101, 1'b0, -1, -1);
    tick(1'b0, 1'b1, 1'b0);
    run(8'hF0, 0, 3, 1'b0, 8'b11110000, 1'b1, -1, -1);
    run(8'hAA, 0, 0, 1'b0, 8'b10101010, 1'b1, -1, -1);
    run(8'hF0, 1, 1, 1'b1, 8'b00001111, 1'b1, -1, -1);
    tick(1'b0, 1'b1, 1'b0);

    en = 1'b1;
    abort = 1'b1;
    pattern = 8'hFF;
    tick(1'b0, 1'b1, 1'b0);
    en = 1'b0;
    abort = 1'b0;
    tick(1'b0, 1'b1, 1'b0);

    run(8'h81, 255, 0, 1'b1, 8'b10000001, 1'b0, -1, -1);
    tick(1'b0, 1'b1, 1'b0);

    run(8'h55, 0, 0, 1'b0, 8'b01010101, 1'b0, 3, -1);
    repeat (4) tick(1'b0, 1'b1, 1'b0);

    run(8'h55, 0, 0, 1'b0, 8'b01010101, 1'b0, -1, 4);
    repeat (3) tick(1'b0, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
